da_fir_serial: RTL

DA_FIR_SERIAL -- requirements
Module: da_fir_serial

---
 rtl/da_fir_serial.sv | 117 +++++++++++
 1 files changed

// File: rtl/da_fir_serial.sv
// Bit-serial distributed-arithmetic FIR: one sample bit per cycle (LSB first) indexes a
// constant partial-sum LUT built from COEFS, so the datapath needs only add/subtract.
module da_fir_serial #(
    parameter int unsigned          DW    = 8,
    parameter int unsigned          CW    = 8,
    parameter int unsigned          NTAPS = 4,
    parameter logic [NTAPS*CW-1:0]  COEFS = {8'hF1, 8'hF6, 8'h09, 8'h05},
    parameter int unsigned          OW    = DW + CW + $clog2(NTAPS)
) (
    input  logic          clk_bit,
    input  logic          rst,
    input  logic [DW-1:0] x_in,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    output logic [OW-1:0] y_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
);

    localparam int unsigned NLUT = 2 ** NTAPS;
    localparam int unsigned CNTW = $clog2(DW);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    // Sum of the coefficients selected by the set bits of idx, sign-extended to OW.
    function automatic logic signed [OW-1:0] lut_entry(input int unsigned idx);
        logic signed [OW-1:0] s;
        s = '0;
        for (int k = 0; k < NTAPS; k++) begin
            if (idx[k]) s = s + OW'(signed'(COEFS[k*CW +: CW]));
        end
        return s;
    endfunction

    logic signed [OW-1:0] w_lut [NLUT];
    for (genvar i = 0; i < NLUT; i++) begin : g_lut
        assign w_lut[i] = lut_entry(i);
    end

    state_e               r_state;
    logic [DW-1:0]        r_taps [NTAPS];
    logic [CNTW-1:0]      r_cnt;
    logic signed [OW-1:0] r_acc;
    logic [OW-1:0]        r_y;
    logic                 r_out_valid;
    logic                 r_busy;

    logic [NTAPS-1:0]     w_idx;
    logic signed [OW-1:0] w_term;
    logic signed [OW-1:0] w_acc_d;
    logic                 w_last;
    logic                 w_accept;

    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            w_idx[k] = r_taps[k][r_cnt];
        end
        w_last  = (r_cnt == CNTW'(DW - 1));
        w_term  = w_lut[w_idx] <<< r_cnt;
        // The sign bit of a two's-complement sample carries negative weight.
        w_acc_d = w_last ? (r_acc - w_term) : (r_acc + w_term);
    end

    assign in_ready  = (r_state == StIdle) && !flush && !rst;
    assign w_accept  = in_valid && in_ready;
    assign y_out     = r_y;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

    always_ff @(posedge clk_bit or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            for (int k = 0; k < NTAPS; k++) r_taps[k] <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (flush) begin
                        for (int k = 0; k < NTAPS; k++) r_taps[k] <= '0;
                    end else if (w_accept) begin
                        r_taps[0] <= x_in;
                        for (int k = 1; k < NTAPS; k++) r_taps[k] <= r_taps[k-1];
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StShift;
                    end
                end
                StShift: begin
                    r_acc <= w_acc_d;
                    if (w_last) begin
                        r_y         <= w_acc_d;
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
